// File: rtl/serial_rx_sp.sv
// serial_rx_sp -- serial-to-parallel frame receiver.
//
// Recovers one frame from the serial line: a start bit (0), DATA_BITS data
// bits sent MSB first, then a stop bit (1). The line is sampled on a
// sampleTick enable running at OVERSAMPLE x the bit rate. A good frame
// updates 'out' and raises a one-clk 'valid' strobe. A frame whose stop bit
// reads 0 raises a one-clk 'frameErr' strobe and leaves 'out' untouched.
//
// Optional build macro: SERIAL_RX_MAJORITY_EN
//   When defined, each START/DATA/STOP decision is a 2-of-3 majority vote
//   over three consecutive ticks instead of a single sample. Ports and
//   timing are the same in both builds.
//
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active low
//   sampleTick one-clk enable at OVERSAMPLE x bit rate; all counting uses it
//   in         serial line, idles high, asynchronous to clk
//   out        last correctly received byte
//   valid      one-clk pulse, out holds a newly received good frame
//   frameErr   one-clk pulse, stop bit was sampled low
//   busy       high whenever the receiver is not idle

module serial_rx_sp #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sampleTick,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    output logic                 frameErr,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state, stateNext;
    logic [TW-1:0]          tickCnt, tickNext;
    logic [BW-1:0]          bitIdx, bitNext;
    logic [DATA_BITS-1:0]   shiftReg, shiftNext;
    logic [DATA_BITS-1:0]   outNext;
    logic                   validNext, errNext;
    logic                   rxMeta, rxS;
    logic                   sample;

    // Two-flop synchronizer. Both flops reset high so a reset never looks
    // like a start edge on an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= in;
            rxS    <= rxMeta;
        end
    end

`ifdef SERIAL_RX_MAJORITY_EN
    // Vote history holds rxS from the two previous ticks. Together with the
    // current rxS it forms a three-tick window that ends on the decision
    // tick, so the decision lands on exactly the same tick as the
    // single-sample build and a one-tick glitch on the decision tick is
    // outvoted.
    logic [1:0] vote;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote <= 2'b11;
        end else if (sampleTick) begin
            vote <= {vote[0], rxS};
        end
    end

    assign sample = (vote[1] & vote[0]) | (vote[1] & rxS) | (vote[0] & rxS);
`else
    assign sample = rxS;
`endif

    assign busy = (state != IDLE);

    // State, counters, shift register and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            out      <= '0;
            valid    <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            state    <= stateNext;
            tickCnt  <= tickNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            out      <= outNext;
            valid    <= validNext;
            frameErr <= errNext;
        end
    end

    // Next-state logic. Everything holds unless sampleTick is high, except
    // the strobes, which default low so they clear on the very next clk.
    // The start check sits half a bit after the detected falling edge; every
    // later sample is one full bit period after the previous one, so all
    // samples land mid-bit. Leaving STOP at mid-bit lets a back-to-back
    // start edge be caught right away.
    always_comb begin
        stateNext = state;
        tickNext  = tickCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        outNext   = out;
        validNext = 1'b0;
        errNext   = 1'b0;

        if (sampleTick) begin
            case (state)
                IDLE: begin
                    if (!rxS) begin
                        tickNext  = '0;
                        stateNext = START;
                    end
                end
                START: begin
                    if (tickCnt == HALF_TICK) begin
                        tickNext = '0;
                        if (!sample) begin
                            bitNext   = '0;
                            stateNext = DATA;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        tickNext = tickCnt + TW'(1);
                    end
                end
                DATA: begin
                    if (tickCnt == LAST_TICK) begin
                        shiftNext = {shiftReg[DATA_BITS-2:0], sample};
                        tickNext  = '0;
                        if (bitIdx == LAST_BIT) begin
                            stateNext = STOP;
                        end else begin
                            bitNext = bitIdx + BW'(1);
                        end
                    end else begin
                        tickNext = tickCnt + TW'(1);
                    end
                end
                STOP: begin
                    if (tickCnt == LAST_TICK) begin
                        if (sample) begin
                            outNext   = shiftReg;
                            validNext = 1'b1;
                        end else begin
                            errNext = 1'b1;
                        end
                        tickNext  = '0;
                        stateNext = IDLE;
                    end else begin
                        tickNext = tickCnt + TW'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_sp.sv
// tb_serial_rx_sp -- scoreboard bench for serial_rx_sp.
//
// Stimulus drives the serial line one sampleTick period at a time (four clk
// per tick) and pushes the expected pulse for each frame into a queue. A
// monitor watches valid/frameErr on every falling clk edge, pops the queue
// and compares the pulse type and the output byte.
// Honours SERIAL_RX_MAJORITY_EN for the glitch-tolerance frame.

module tb_serial_rx_sp;

    typedef struct {
        logic       isErr;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       sampleTick;
    logic       in;
    logic [7:0] out;
    logic       valid;
    logic       frameErr;
    logic       busy;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expQ[$];
    exp_t popped;

    serial_rx_sp #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sampleTick(sampleTick),
        .in        (in),
        .out       (out),
        .valid     (valid),
        .frameErr  (frameErr),
        .busy      (busy)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL timeout: run exceeded its time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] timeout");
    end

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (valid || frameErr) begin
            vectors++;
            if (valid && frameErr) begin
                miscompares++;
                $display("[TB] FAIL pulseOverlap: valid=%b frameErr=%b, required not both high", valid, frameErr);
            end
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpectedPulse: valid=%b frameErr=%b out=%h, required no pulse", valid, frameErr, out);
            end else begin
                popped = expQ.pop_front();
                if (frameErr !== popped.isErr) begin
                    miscompares++;
                    $display("[TB] FAIL pulseKind: frameErr=%b, required %b", frameErr, popped.isErr);
                end
                vectors++;
                if (out !== popped.data) begin
                    miscompares++;
                    $display("[TB] FAIL pulseData: out=%h, required %h", out, popped.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // One sampleTick period: line set at a falling edge, tick on the fourth
    // rising edge, so the synchronized value is already in rxS at the tick.
    task automatic applyStimulus(input logic v);
        in         = v;
        sampleTick = 1'b0;
        repeat (3) @(negedge clk);
        sampleTick = 1'b1;
        @(negedge clk);
        sampleTick = 1'b0;
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1);
    endtask

    // Sends up to maxTicks ticks of a frame. With glitch set, the centre
    // tick (local tick 8) of every data bit is inverted.
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic glitch, input int maxTicks);
        logic [9:0] frame;
        logic       v;
        frame = {1'b0, d, stopBit};
        for (int k = 0; k < maxTicks; k++) begin
            v = frame[9 - (k / 16)];
            if (glitch && (k % 16 == 8) && (k / 16 >= 1) && (k / 16 <= 8)) v = ~v;
            applyStimulus(v);
        end
    endtask

    task automatic pushExp(input logic isErr, input logic [7:0] data);
        exp_t e;
        e.isErr = isErr;
        e.data  = data;
        expQ.push_back(e);
    endtask

    initial begin
        int busyTicks;
        reset      = 1'b0;
        in         = 1'b1;
        sampleTick = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("resetOut", 32'(out), 32'h00);
        checkOutput("resetValid", 32'(valid), 32'h0);
        checkOutput("resetFrameErr", 32'(frameErr), 32'h0);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        reset = 1'b1;
        sendIdle(20);

        $display("[TB] frame 0xA5");
        pushExp(1'b0, 8'hA5);
        sendFrame(8'hA5, 1'b1, 1'b0, 160);
        checkOutput("busyAfterA5", 32'(busy), 32'h0);
        sendIdle(4);

        $display("[TB] four-tick low glitch");
        busyTicks = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i < 4) ? 1'b0 : 1'b1);
            if (busy) busyTicks++;
        end
        checkOutput("glitchBusyTicks", 32'(busyTicks), 32'd8);
        checkOutput("glitchOutHeld", 32'(out), 32'hA5);
        sendIdle(10);

        $display("[TB] frame 0x3C with bad stop bit");
        pushExp(1'b1, 8'hA5);
        sendFrame(8'h3C, 1'b0, 1'b0, 160);
        sendIdle(20);
        checkOutput("errOutHeld", 32'(out), 32'hA5);

        $display("[TB] back-to-back 0x00, 0xFF");
        pushExp(1'b0, 8'h00);
        pushExp(1'b0, 8'hFF);
        sendFrame(8'h00, 1'b1, 1'b0, 160);
        sendFrame(8'hFF, 1'b1, 1'b0, 160);
        sendIdle(20);
        checkOutput("b2bOut", 32'(out), 32'hFF);

        $display("[TB] reset during data bit 4");
        sendFrame(8'h5A, 1'b1, 1'b0, 88);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abortBusy", 32'(busy), 32'h0);
        checkOutput("abortOut", 32'(out), 32'h00);
        reset = 1'b1;
        sendIdle(20);
        pushExp(1'b0, 8'h81);
        sendFrame(8'h81, 1'b1, 1'b0, 160);
        sendIdle(20);

        $display("[TB] 0x55 with centre-tick glitches");
`ifdef SERIAL_RX_MAJORITY_EN
        pushExp(1'b0, 8'h55);
`else
        pushExp(1'b0, 8'hAA);
`endif
        sendFrame(8'h55, 1'b1, 1'b1, 160);
        sendIdle(20);

        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        checkOutput("finalBusy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
